writeback_stage: RTL

Final pipeline stage of the MIPS datapath, directly upstream of the 32×32 register file's synchronous write port. Accepts completed instructions from the execute stage over a valid/ready handshake, performs the data-memory read for loads (variable-latency req/ack), aligns and extends load data, and drives `WriteData`, `WriteRegister` and `RegWrite` for exactly one cycle per register-writing instruction.

---
 rtl/wb_pkg.sv | 31 +++
 rtl/load_align.sv | 39 +++
 rtl/writeback_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: instruction kinds, load sizes,
// FSM state encoding and the load alignment rule.
package wb_pkg;

    localparam logic [1:0] KIND_ALU  = 2'b00;
    localparam logic [1:0] KIND_LOAD = 2'b01;
    localparam logic [1:0] KIND_NONE = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEM   = 2'd1,
        ST_WRITE = 2'd2
    } wb_state_t;

    // The reserved size code behaves as a word, so it shares the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lo[0];
            default:   bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian lane select and sign/zero extension of a memory read word.
module load_align
    import wb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       lo,
    input  logic [1:0]       size,
    input  logic             is_unsigned,
    output logic [WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (size)
            SIZE_BYTE: data = is_unsigned ? {{(WIDTH-8){1'b0}}, byte_sel}
                                          : {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            SIZE_HALF: data = is_unsigned ? {{(WIDTH-16){1'b0}}, half_sel}
                                          : {{(WIDTH-16){half_sel[15]}}, half_sel};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final MIPS pipeline stage: accepts results, performs the data-memory read for
// loads, aligns load data and issues one-cycle register file writes.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [WIDTH-1:0]  InResult,
    input  logic [REG_AW-1:0] InDest,
    input  logic [1:0]        InKind,
    input  logic [1:0]        InSize,
    input  logic              InUnsigned,
    output logic              MemReq,
    output logic [WIDTH-1:0]  MemAddr,
    input  logic              MemAck,
    input  logic [WIDTH-1:0]  MemRdata,
    output logic [WIDTH-1:0]  WriteData,
    output logic [REG_AW-1:0] WriteRegister,
    output logic              RegWrite,
    output logic              AlignErr,
    output logic [1:0]        State
);

    // Handshake: a transfer happens at a rising edge where InValid && InReady;
    // InValid may be held across cycles, the offer is consumed only on transfer.
    wb_state_t         state_q, state_d;
    logic              accept;
    logic              mem_req_d, reg_write_d, align_err_d, ld_uns_q, ld_uns_d;
    logic [WIDTH-1:0]  mem_addr_d, write_data_d, aligned;
    logic [REG_AW-1:0] write_reg_d;
    logic [1:0]        ld_size_q, ld_size_d, ld_lo_q, ld_lo_d;

    assign InReady = (state_q != ST_MEM);
    assign accept  = InValid && InReady;
    assign State   = state_q;

    load_align #(.WIDTH(WIDTH)) u_align (
        .rdata       (MemRdata),
        .lo          (ld_lo_q),
        .size        (ld_size_q),
        .is_unsigned (ld_uns_q),
        .data        (aligned)
    );

    always_comb begin
        state_d      = state_q;
        mem_req_d    = MemReq;
        mem_addr_d   = MemAddr;
        write_data_d = WriteData;
        write_reg_d  = WriteRegister;
        reg_write_d  = 1'b0;
        align_err_d  = AlignErr;
        ld_size_d    = ld_size_q;
        ld_lo_d      = ld_lo_q;
        ld_uns_d     = ld_uns_q;
        case (state_q)
            ST_MEM: begin
                if (MemAck) begin
                    write_data_d = aligned;
                    mem_req_d    = 1'b0;
                    reg_write_d  = (WriteRegister != '0);
                    state_d      = ST_WRITE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    case (InKind)
                        KIND_ALU: begin
                            write_data_d = InResult;
                            write_reg_d  = InDest;
                            reg_write_d  = (InDest != '0);
                            state_d      = ST_WRITE;
                        end
                        KIND_LOAD: begin
                            if (is_misaligned(InSize, InResult[1:0])) begin
                                align_err_d = 1'b1;
                            end else begin
                                mem_addr_d  = {InResult[WIDTH-1:2], 2'b00};
                                mem_req_d   = 1'b1;
                                write_reg_d = InDest;
                                ld_size_d   = InSize;
                                ld_lo_d     = InResult[1:0];
                                ld_uns_d    = InUnsigned;
                                state_d     = ST_MEM;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            MemReq        <= 1'b0;
            MemAddr       <= '0;
            WriteData     <= '0;
            WriteRegister <= '0;
            RegWrite      <= 1'b0;
            AlignErr      <= 1'b0;
            ld_size_q     <= SIZE_WORD;
            ld_lo_q       <= 2'b00;
            ld_uns_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            MemReq        <= mem_req_d;
            MemAddr       <= mem_addr_d;
            WriteData     <= write_data_d;
            WriteRegister <= write_reg_d;
            RegWrite      <= reg_write_d;
            AlignErr      <= align_err_d;
            ld_size_q     <= ld_size_d;
            ld_lo_q       <= ld_lo_d;
            ld_uns_q      <= ld_uns_d;
        end
    end

endmodule
